// File: rtl/record_pkg.sv
// Shared constants and state encoding for the record sequencer and related lane-level blocks.
package record_pkg;

  localparam int WORD_W = 256;
  localparam int LANES  = 4;
  localparam int LANE_W = 64;
  localparam int HDR_W  = 3;
  localparam int EOF_W  = 5;
  localparam logic [HDR_W-1:0] HDR_MARK = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Lane 0 occupies the most significant 64 bits of the word.
  function automatic logic [LANE_W-1:0] lane_of(input logic [WORD_W-1:0] word,
                                                input logic [1:0] idx);
    case (idx)
      2'd0:    lane_of = word[255:192];
      2'd1:    lane_of = word[191:128];
      2'd2:    lane_of = word[127:64];
      default: lane_of = word[63:0];
    endcase
  endfunction

endpackage

// File: rtl/lane_detect.sv
// Combinational classifier: flags lanes carrying a record header and those that are end-of-frame.
module lane_detect
  import record_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [LANES-1:0]  mask,
  output logic [LANES-1:0]  eofm
);

  logic [LANE_W-1:0] lane;

  always_comb begin
    mask = '0;
    eofm = '0;
    lane = '0;
    for (int i = 0; i < LANES; i++) begin
      lane    = lane_of(word, 2'(i));
      mask[i] = (lane[LANE_W-1 -: HDR_W] == HDR_MARK);
      eofm[i] = mask[i] && (lane[LANE_W-HDR_W-1 -: EOF_W] == '0);
    end
  end

endmodule

// File: rtl/record_sequencer.sv
// Unpacks 256-bit words into a 64-bit record stream, one marked lane per handshake, until EOF.
module record_sequencer
  import record_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LANE_W-1:0] out_data,
  output logic [1:0]        out_lane,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  rec_count,
  output logic              overflow
);

  state_t            state_p0;
  logic [WORD_W-1:0] hold_p0;
  logic [LANES-1:0]  mask_p0;
  logic [LANES-1:0]  eofm_p0;

  logic [LANES-1:0]  in_mask;
  logic [LANES-1:0]  in_eofm;
  logic [LANES-1:0]  sel_onehot;
  logic [LANES-1:0]  mask_rest;
  logic [1:0]        sel;
  logic              in_fire;
  logic              out_fire;
  logic              cnt_sat;

  lane_detect u_detect (
    .word (in_data),
    .mask (in_mask),
    .eofm (in_eofm)
  );

  // Lowest-index marked lane wins.
  always_comb begin
    sel = 2'd0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_p0[i]) sel = 2'(i);
    end
  end

  assign sel_onehot = 4'b0001 << sel;
  assign mask_rest  = mask_p0 & ~sel_onehot;

  assign in_ready  = (state_p0 == ST_SCAN);
  assign out_valid = (state_p0 == ST_EMIT);
  assign busy      = (state_p0 != ST_IDLE);
  assign done      = (state_p0 == ST_DONE);
  assign out_data  = lane_of(hold_p0, sel);
  assign out_lane  = sel;
  assign out_last  = out_valid && eofm_p0[sel];

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign cnt_sat   = &rec_count;

  // Stage p0: captured word, lane masks, frame control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= ST_IDLE;
      hold_p0   <= '0;
      mask_p0   <= '0;
      eofm_p0   <= '0;
      rec_count <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state_p0)
        ST_IDLE: begin
          if (start) begin
            rec_count <= '0;
            overflow  <= 1'b0;
            state_p0  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (in_fire) begin
            hold_p0 <= in_data;
            mask_p0 <= in_mask;
            eofm_p0 <= in_eofm;
            if (in_mask != '0) state_p0 <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_fire) begin
            if (cnt_sat) overflow  <= 1'b1;
            else         rec_count <= rec_count + 1'b1;
            // EOF discards any higher lanes still pending in this word.
            if (eofm_p0[sel]) begin
              mask_p0  <= '0;
              state_p0 <= ST_DONE;
            end else begin
              mask_p0 <= mask_rest;
              if (mask_rest == '0) state_p0 <= ST_SCAN;
            end
          end
        end
        ST_DONE: state_p0 <= ST_IDLE;
        default: state_p0 <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_record_sequencer.sv
// Scoreboard bench for record_sequencer: directed words, queued expected records, negedge monitor.
module tb_record_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] in_data;
  logic         in_valid;
  logic         out_ready;

  logic         in_ready, out_last, out_valid, busy, done, overflow;
  logic [63:0]  out_data;
  logic [1:0]   out_lane;
  logic [15:0]  rec_count;

  logic         in_ready2, out_last2, out_valid2, busy2, done2, overflow2;
  logic [63:0]  out_data2;
  logic [1:0]   out_lane2;
  logic [1:0]   rec_count2;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  lane;
    logic        last;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  localparam logic [63:0] A0 = 64'hE100_0000_0000_0001;
  localparam logic [63:0] A1 = 64'hE200_0000_0000_0002;
  localparam logic [63:0] A2 = 64'hE300_0000_0000_0003;
  localparam logic [63:0] A3 = 64'hFF00_0000_0000_0004;
  localparam logic [63:0] B1 = 64'hE500_0000_0000_0011;
  localparam logic [63:0] B3 = 64'hE000_0000_0000_00FF;
  localparam logic [63:0] C0 = 64'hE000_0000_0000_0A0A;
  localparam logic [63:0] C2 = 64'hE700_0000_0000_0022;
  localparam logic [63:0] C3 = 64'hF000_0000_0000_0033;
  localparam logic [63:0] D0 = 64'hE800_0000_0000_0041;
  localparam logic [63:0] D1 = 64'hE900_0000_0000_0042;
  localparam logic [63:0] D2 = 64'hEA00_0000_0000_0043;
  localparam logic [63:0] D3 = 64'hEB00_0000_0000_0044;
  localparam logic [63:0] U0 = 64'hC000_0000_0000_0055;

  always #5 clk = ~clk;

  record_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .rec_count(rec_count), .overflow(overflow)
  );

  record_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .out_data(out_data2), .out_lane(out_lane2), .out_last(out_last2),
    .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2), .done(done2),
    .rec_count(rec_count2), .overflow(overflow2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] data, input logic [1:0] lane, input logic last);
    rec_t r;
    r = {data, lane, last};
    exp_q.push_back(r);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns at #1 after the edge on which the word was taken.
  task automatic send(input logic [255:0] w);
    bit taken = 0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        taken = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!taken) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got in_ready=0 for 40 cycles, required 1");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_record: got lane %0d data %h, required none", out_lane, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rec_data", out_data, mon_e.data);
        chk("rec_lane", 64'(out_lane), 64'(mon_e.lane));
        chk("rec_last", 64'(out_last), 64'(mon_e.last));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rec_count", 64'(rec_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    rst = 1'b0;
    tick();

    // Lanes 1 and 3 marked, lane 3 is EOF
    push(B1, 2'd1, 1'b0);
    push(B3, 2'd3, 1'b1);
    pulse_start();
    chk("t2_busy", 64'(busy), 64'd1);
    chk("t2_in_ready", 64'(in_ready), 64'd1);
    send({64'h0, B1, 64'h0000_0000_0000_1234, B3});
    chk("t2_first_valid", 64'(out_valid), 64'd1);
    tick(); tick();
    chk("t2_done_pulse", 64'(done), 64'd1);
    chk("t2_done_busy", 64'(busy), 64'd1);
    tick();
    chk("t2_done_drop", 64'(done), 64'd0);
    chk("t2_idle_busy", 64'(busy), 64'd0);
    chk("t2_rec_count", 64'(rec_count), 64'd2);
    chk("t2_queue", 64'(exp_q.size()), 64'd0);

    // EOF in lane 0 with lanes 2,3 also marked
    push(C0, 2'd0, 1'b1);
    pulse_start();
    send({C0, 64'h0, C2, C3});
    chk("t3_valid", 64'(out_valid), 64'd1);
    tick();
    chk("t3_done", 64'(done), 64'd1);
    tick();
    chk("t3_idle", 64'(busy), 64'd0);
    chk("t3_rec_count", 64'(rec_count), 64'd1);
    chk("t3_queue", 64'(exp_q.size()), 64'd0);

    // Four marked lanes, no EOF, out_ready high
    push(A0, 2'd0, 1'b0); push(A1, 2'd1, 1'b0);
    push(A2, 2'd2, 1'b0); push(A3, 2'd3, 1'b0);
    pulse_start();
    send({A0, A1, A2, A3});
    chk("t1_valid_n1", 64'(out_valid), 64'd1);
    chk("t1_lane_n1", 64'(out_lane), 64'd0);
    chk("t1_in_ready_n1", 64'(in_ready), 64'd0);
    tick(); tick(); tick(); tick();
    chk("t1_in_ready_5th", 64'(in_ready), 64'd1);
    chk("t1_out_valid_5th", 64'(out_valid), 64'd0);
    chk("t1_rec_count", 64'(rec_count), 64'd4);
    chk("t1_queue", 64'(exp_q.size()), 64'd0);

    // Backpressure for 5 cycles
    push(D0, 2'd0, 1'b0); push(D1, 2'd1, 1'b0);
    push(D2, 2'd2, 1'b0); push(D3, 2'd3, 1'b0);
    out_ready = 1'b0;
    send({D0, D1, D2, D3});
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_data", out_data, D0);
      chk("bp_lane", 64'(out_lane), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    drain();
    tick();
    chk("bp_rec_count", 64'(rec_count), 64'd8);
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);

    // Unmarked word dropped; start while busy ignored
    send({U0, U0, U0, U0});
    chk("unm_in_ready", 64'(in_ready), 64'd1);
    chk("unm_out_valid", 64'(out_valid), 64'd0);
    pulse_start();
    chk("busy_start_busy", 64'(busy), 64'd1);
    chk("busy_start_count", 64'(rec_count), 64'd8);
    chk("busy_start_in_ready", 64'(in_ready), 64'd1);

    // Reset after two of four records
    push(A0, 2'd0, 1'b0); push(A1, 2'd1, 1'b0);
    send({A0, A1, A2, A3});
    tick(); tick();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_last", 64'(out_last), 64'd0);
    chk("mid_rst_out_lane", 64'(out_lane), 64'd0);
    chk("mid_rst_out_data", out_data, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_count", 64'(rec_count), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_queue", 64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Five records: saturates the 2-bit counter
    push(A0, 2'd0, 1'b0); push(A1, 2'd1, 1'b0);
    push(A2, 2'd2, 1'b0); push(A3, 2'd3, 1'b0);
    push(C0, 2'd0, 1'b1);
    pulse_start();
    send({A0, A1, A2, A3});
    send({C0, 64'h0, C2, C3});
    drain();
    tick(); tick(); tick();
    chk("sat_count_w2", 64'(rec_count2), 64'd3);
    chk("sat_overflow_w2", 64'(overflow2), 64'd1);
    chk("sat_count_w16", 64'(rec_count), 64'd5);
    chk("sat_overflow_w16", 64'(overflow), 64'd0);
    chk("sat_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/record_sequencer.md
# record_sequencer

Controller that moves packed 256-bit words from an upstream stream into a 64-bit record stream. Each word holds four 64-bit lanes. A lane whose top three bits are `111` is a valid record. A valid record whose next five bits are zero is the end-of-frame (EOF) record. The block captures one word at a time and emits its marked lanes one per handshake, in lane order. It stops at EOF, counts records, and sits between the word-fetch buffer and the downstream record consumer.

## Interface
Parameters:
- `CNT_W`, 16: width of the record counter.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a frame. Ignored unless the block is in IDLE.
- `in_data` in 256: packed word. Lane 0 = [255:192], lane 1 = [191:128], lane 2 = [127:64], lane 3 = [63:0].
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: the block will accept a word this cycle.
- `out_data` out 64: current record.
- `out_lane` out 2: source lane index of `out_data`.
- `out_last` out 1: the current record is the EOF record.
- `out_valid` out 1: record valid.
- `out_ready` in 1: downstream accepts the record.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when a frame completes.
- `rec_count` out CNT_W: records accepted downstream in the current frame.
- `overflow` out 1: sticky. Set when `rec_count` saturates.

## Operation
States are IDLE, SCAN, EMIT and DONE.

- **IDLE:** `in_ready`=0, `out_valid`=0. On `start`:
  - clear `rec_count` and `overflow`;
  - go to SCAN.
- **SCAN:** `in_ready`=1. On an input handshake:
  - latch `in_data` into the hold register;
  - compute `mask[3:0]`: bit i set when lane i bits [63:61] = `111`;
  - compute `eofm[3:0]`: bit i set when `mask[i]` and lane i bits [60:56] = 0.
  - If mask = 0, drop the word and stay in SCAN. Otherwise go to EMIT.
- **EMIT:** `in_ready`=0. Select the lowest-index set bit of mask.
  - `out_valid`=1, `out_data` = that lane, `out_lane` = its index, `out_last` = `eofm` of that lane.
  - On `out_valid && out_ready`: clear that mask bit and increment `rec_count`.
  - If the accepted record had `out_last`=1, go to DONE. Any higher-index lanes still marked are discarded.
  - Otherwise, if the remaining mask is 0, go to SCAN. Otherwise stay in EMIT with the next lane.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE. `rec_count` holds its value until the next `start`.

Counter rules:
- `rec_count` saturates at 2^CNT_W−1.
- An acceptance that arrives while the counter is saturated sets `overflow` and leaves the count unchanged.

Boundary conditions:
- `start` outside IDLE: ignored. No counter clear.
- `in_valid` outside SCAN: not accepted, because `in_ready`=0.
- `out_ready` low in EMIT: `out_data`, `out_lane`, `out_last` and `out_valid` stay stable until accepted.
- EOF in lane 0 with lanes 1–3 also marked: only lane 0 is emitted, then DONE.
- Reset in any state:
  - next state is IDLE;
  - mask, hold register, `rec_count` and `overflow` are cleared;
  - a partially emitted word is lost.

Reset values: `in_ready`=0, `out_valid`=0, `out_last`=0, `out_lane`=0, `out_data`=0, `busy`=0, `done`=0, `rec_count`=0, `overflow`=0.

## Timing
- Word accepted at edge N: the first record has `out_valid`=1 in cycle N+1.
- With `out_ready` held high, a word with k marked lanes (no EOF) takes k EMIT cycles plus 1 SCAN cycle.
- `in_ready` rises in the cycle after the last record of a word is accepted.
- A word with no marked lanes costs one SCAN cycle.
- The EOF record is accepted at edge M. `done`=1 during cycle M+1, and `busy`=0 from cycle M+2.
- All outputs are driven from registers or from state alone. There are no combinational paths from input to output.

## Structure
Shared package `record_pkg` holds:
- `WORD_W`=256, `LANES`=4, `LANE_W`=64;
- `HDR_MARK`=3'b111, `HDR_W`=3, `EOF_W`=5;
- the state enum typedef.

Sub-module `lane_detect` (combinational) maps a 256-bit word to `mask` and `eofm`. It is reused by the frame-statistics block.

## Test plan
- `start`, then one word with all four lanes `111` and nonzero [60:56], `out_ready`=1:
  - lanes 0,1,2,3 are emitted on 4 consecutive cycles, each with `out_last`=0;
  - `in_ready` is high on the 5th cycle;
  - `rec_count`=4.
- A word with only lanes 1 and 3 marked, where lane 3 is EOF (bits [60:56]=0):
  - two records are emitted, `out_lane`=1 then 3, and the second has `out_last`=1;
  - `done` pulses one cycle later, then IDLE with `rec_count`=2.
- EOF in lane 0 with lanes 2 and 3 also marked:
  - a single record is emitted with `out_last`=1, then DONE;
  - `rec_count`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in EMIT:
  - `out_data` and `out_lane` stay stable and `in_ready` stays 0;
  - after release, emission resumes with no record lost or duplicated.
- An unmarked word (all lane top bits `110`): no output, word dropped, `in_ready` stays high. `start` pulsed while busy is ignored and `rec_count` is unchanged.
- Assert `rst` mid-EMIT (2 of 4 records sent): next cycle all outputs are at reset values. Then, with `CNT_W`=2, send 5 records: `rec_count`=3 and `overflow`=1.
